divsigned_seq: RTL and testbench

Iterative radix-2 signed integer divider, the inverse datapath of the combinational signed multiplier. It takes an `IN_SIZE_0`-bit signed dividend and an `IN_SIZE_1`-bit signed divisor. It returns a truncating quotient and remainder, so a multiplier product can be divided back by one of its factors. It sits in the arithmetic unit behind a valid/ready handshake on both sides and processes one operation at a time.

---
 rtl/divsigned_seq_pkg.sv | 7 +
 rtl/divsigned_seq_if.sv | 14 +
 rtl/divsigned_step.sv | 16 +
 rtl/divsigned_seq.sv | 96 +++++++++
 tb/tb_divsigned_seq.sv | 151 +++++++++++++++
 5 files changed

// File: rtl/divsigned_seq_pkg.sv
// divsigned_seq_pkg: FSM state type and counter sizing shared by the divider
package divsigned_seq_pkg;
  typedef enum logic [1:0] {IDLE, CALC, FIX, DONE} state_t;
  function automatic int cnt_w(input int n);
    return $clog2(n + 1);
  endfunction
endpackage

// File: rtl/divsigned_seq_if.sv
// divsigned_seq_if: operand and result handshakes of the signed divider
interface divsigned_seq_if #(parameter int IN_SIZE_0 = 12, parameter int IN_SIZE_1 = 8);
  logic in_valid_i, in_ready_o, out_valid_o, out_ready_i, div_zero_o;
  logic [IN_SIZE_0-1:0] dividend_i, quot_o;
  logic [IN_SIZE_1-1:0] divisor_i, rem_o;
  modport master (
    output in_valid_i, dividend_i, divisor_i, out_ready_i,
    input in_ready_o, out_valid_o, quot_o, rem_o, div_zero_o
  );
  modport slave (
    input in_valid_i, dividend_i, divisor_i, out_ready_i,
    output in_ready_o, out_valid_o, quot_o, rem_o, div_zero_o
  );
endinterface

// File: rtl/divsigned_step.sv
// divsigned_step: one restoring division iteration on unsigned magnitudes
module divsigned_step #(parameter int W = 8) (
  input  logic [W:0]   pr,
  input  logic         b,
  input  logic [W-1:0] dvs,
  output logic [W:0]   pr_n,
  output logic         q
);
  logic [W+1:0] sh, t;
  always_comb begin
    sh = {pr, b};
    t = sh - {2'b0, dvs};
    q = ~t[W+1];
    pr_n = q ? t[W:0] : sh[W:0];
  end
endmodule

// File: rtl/divsigned_seq.sv
// divsigned_seq: iterative radix-2 signed divider, truncating quotient, remainder signed like dividend
// Define DIVSIGNED_SEQ_ASSERT_EN to compile in the embedded SVA checks.
module divsigned_seq
  import divsigned_seq_pkg::*;
#(
  parameter int IN_SIZE_0 = 12,
  parameter int IN_SIZE_1 = 8
) (
  input logic clk_i,
  input logic rst_ni,
  divsigned_seq_if.slave bus
);
  localparam int CW = cnt_w(IN_SIZE_0);
  state_t state, state_n;
  logic [CW-1:0] cnt;
  logic [IN_SIZE_0-1:0] dd;
  logic [IN_SIZE_1:0] pr, pr_n;
  logic [IN_SIZE_1-1:0] dvs;
  logic q_neg, r_neg, qb, hs_in, hs_out, sd, sv, dz_in;
  divsigned_step #(.W(IN_SIZE_1)) u_step (
    .pr(pr), .b(dd[IN_SIZE_0-1]), .dvs(dvs), .pr_n(pr_n), .q(qb)
  );
  always_comb begin
    sd = bus.dividend_i[IN_SIZE_0-1];
    sv = bus.divisor_i[IN_SIZE_1-1];
    dz_in = bus.divisor_i == '0;
    bus.in_ready_o = rst_ni && state == IDLE;
    bus.out_valid_o = state == DONE;
    hs_in = bus.in_ready_o && bus.in_valid_i;
    hs_out = bus.out_valid_o && bus.out_ready_i;
    state_n = state == IDLE ? (hs_in ? (dz_in ? DONE : CALC) : IDLE) :
              state == CALC ? (cnt == CW'(1) ? FIX : CALC) :
              state == FIX  ? DONE :
              (hs_out ? IDLE : DONE);
  end
  always_ff @(posedge clk_i) begin
    if (!rst_ni) state <= IDLE;
    else state <= state_n;
  end
  // dd shifts dividend bits out at the top and collects quotient bits at the bottom
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      bus.quot_o <= '0;
      bus.rem_o <= '0;
      bus.div_zero_o <= 1'b0;
      cnt <= '0;
      dd <= '0;
      pr <= '0;
      dvs <= '0;
      q_neg <= 1'b0;
      r_neg <= 1'b0;
    end else if (hs_in) begin
      dd <= sd ? -bus.dividend_i : bus.dividend_i;
      dvs <= sv ? -bus.divisor_i : bus.divisor_i;
      pr <= '0;
      q_neg <= sd ^ sv;
      r_neg <= sd;
      cnt <= CW'(IN_SIZE_0);
      if (dz_in) begin
        bus.quot_o <= '1;
        bus.rem_o <= '0;
        bus.div_zero_o <= 1'b1;
      end
    end else if (state == CALC) begin
      dd <= {dd[IN_SIZE_0-2:0], qb};
      pr <= pr_n;
      cnt <= cnt - CW'(1);
    end else if (state == FIX) begin
      bus.quot_o <= q_neg ? -dd : dd;
      bus.rem_o <= r_neg ? -pr[IN_SIZE_1-1:0] : pr[IN_SIZE_1-1:0];
      bus.div_zero_o <= 1'b0;
    end
  end
`ifdef DIVSIGNED_SEQ_ASSERT_EN
  logic signed [IN_SIZE_0-1:0] a_dd, a_prod;
  logic signed [IN_SIZE_1-1:0] a_dv;
  logic [IN_SIZE_1-1:0] a_rmag;
  always_ff @(posedge clk_i) begin
    if (hs_in) begin
      a_dd <= bus.dividend_i;
      a_dv <= bus.divisor_i;
    end
  end
  always_comb begin
    a_prod = $signed(bus.quot_o) * IN_SIZE_0'(a_dv) + IN_SIZE_0'($signed(bus.rem_o));
    a_rmag = bus.rem_o[IN_SIZE_1-1] ? -bus.rem_o : bus.rem_o;
  end
  a_hold: assert property (@(posedge clk_i) disable iff (!rst_ni)
    bus.out_valid_o && !bus.out_ready_i |=> bus.out_valid_o && $stable({bus.quot_o, bus.rem_o, bus.div_zero_o}));
  a_excl: assert property (@(posedge clk_i) !(bus.in_ready_o && bus.out_valid_o));
  a_eq: assert property (@(posedge clk_i) disable iff (!rst_ni)
    hs_out && !bus.div_zero_o |-> a_prod == a_dd);
  a_rem: assert property (@(posedge clk_i) disable iff (!rst_ni)
    hs_out && !bus.div_zero_o |-> a_rmag < dvs);
`endif
endmodule

// File: tb/tb_divsigned_seq.sv
// tb_divsigned_seq: scoreboard bench for divsigned_seq against plain integer division
module tb_divsigned_seq;
  localparam int N0 = 12, N1 = 8;
  typedef struct { logic [N0-1:0] q; logic [N1-1:0] r; logic dz; } exp_t;
  logic clk = 1'b0, rst_n = 1'b0;
  int vectors = 0, miscompares = 0, cyc = 0, cyc0 = 0, exp_lat = 0;
  bit hold = 1'b0, rnd = 1'b0;
  exp_t sb[$];
  divsigned_seq_if #(.IN_SIZE_0(N0), .IN_SIZE_1(N1)) bus ();
  divsigned_seq #(.IN_SIZE_0(N0), .IN_SIZE_1(N1)) dut (.clk_i(clk), .rst_ni(rst_n), .bus(bus));
  always #5 clk = ~clk;
  initial forever begin
    @(posedge clk);
    cyc++;
  end
  initial forever begin
    @(posedge clk);
    #1 bus.out_ready_i = hold ? 1'b0 : rnd ? ($urandom_range(0, 3) != 0) : 1'b1;
  end
  task automatic check(input string n, input int act, input int exp);
    vectors++;
    if (act != exp) begin
      miscompares++;
      $display("FAIL %s: got %0d, expected %0d", n, act, exp);
    end
  endtask
  function automatic exp_t model(input int a, input int b);
    exp_t e;
    if (b == 0) begin
      e.q = '1; e.r = '0; e.dz = 1'b1;
    end else begin
      e.q = N0'(a / b); e.r = N1'(a % b); e.dz = 1'b0;
    end
    return e;
  endfunction
  task automatic send(input int a, input int b, input bit push, input bit eager);
    bit done = 1'b0;
    for (int t = 0; t < 300 && !done; t++) begin
      @(negedge clk);
      if (bus.in_ready_o) begin
        bus.in_valid_i = 1'b1;
        bus.dividend_i = N0'(a);
        bus.divisor_i = N1'(b);
        cyc0 = cyc;
        exp_lat = b == 0 ? 1 : 14;
        if (push) sb.push_back(model(a, b));
        done = 1'b1;
      end else begin
        bus.in_valid_i = eager | ($urandom_range(0, 1) == 1);
        bus.dividend_i = eager ? N0'(a) : N0'($urandom);
        bus.divisor_i = eager ? N1'(b) : N1'($urandom);
      end
    end
    if (!done) check("accept timeout", 0, 1);
    @(posedge clk);
    #1 bus.in_valid_i = 1'b0;
  endtask
  task automatic wait_valid();
    for (int t = 0; t < 100 && !bus.out_valid_o; t++) @(negedge clk);
    if (!bus.out_valid_o) check("valid timeout", 0, 1);
  endtask
  task automatic drain();
    for (int t = 0; t < 400 && sb.size() != 0; t++) @(negedge clk);
    if (sb.size() != 0) check("drain timeout", sb.size(), 0);
  endtask
  // Payload is compared every cycle it is valid, so backpressure stability is covered too
  initial begin
    bit prev_v = 1'b0, popped = 1'b0;
    forever begin
      @(negedge clk);
      if (rst_n) begin
        if (popped) check("idle after output", int'({bus.out_valid_o, bus.in_ready_o}), 1);
        popped = 1'b0;
        if (bus.out_valid_o) begin
          if (!prev_v && exp_lat != 0) check("latency", cyc - cyc0, exp_lat);
          check("in_ready in DONE", int'(bus.in_ready_o), 0);
          if (sb.size() == 0) check("spurious result", 1, 0);
          else begin
            check("quot", int'(bus.quot_o), int'(sb[0].q));
            check("rem", int'(bus.rem_o), int'(sb[0].r));
            check("div_zero", int'(bus.div_zero_o), int'(sb[0].dz));
            if (bus.out_ready_i) begin
              void'(sb.pop_front());
              popped = 1'b1;
            end
          end
        end
        prev_v = bus.out_valid_o;
      end else begin
        prev_v = 1'b0;
        popped = 1'b0;
      end
    end
  end
  initial begin
    int da[10] = '{100, -100, 100, -100, -2048, 5, -2048, 2047, -1, 0};
    int dv[10] = '{7, 7, -7, -7, -1, 0, 1, -128, 127, -3};
    int a, b;
    bus.in_valid_i = 1'b0;
    bus.dividend_i = '0;
    bus.divisor_i = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("reset in_ready", int'(bus.in_ready_o), 0);
    check("reset out_valid", int'(bus.out_valid_o), 0);
    check("reset quot", int'(bus.quot_o), 0);
    check("reset rem", int'(bus.rem_o), 0);
    check("reset div_zero", int'(bus.div_zero_o), 0);
    @(posedge clk);
    #1 rst_n = 1'b1;
    for (int i = 0; i < 10; i++) send(da[i], dv[i], 1'b1, 1'b0);
    drain();
    hold = 1'b1;
    send(300, -9, 1'b1, 1'b0);
    wait_valid();
    fork
      begin
        repeat (5) @(posedge clk);
        hold = 1'b0;
      end
    join_none
    send(-777, 13, 1'b1, 1'b1);
    drain();
    send(50, 7, 1'b0, 1'b0);
    repeat (4) @(posedge clk);
    #1 rst_n = 1'b0;
    @(negedge clk);
    check("in_ready under reset", int'(bus.in_ready_o), 0);
    @(negedge clk);
    check("abort out_valid", int'(bus.out_valid_o), 0);
    check("abort quot", int'(bus.quot_o), 0);
    check("abort rem", int'(bus.rem_o), 0);
    check("abort div_zero", int'(bus.div_zero_o), 0);
    @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    check("in_ready after reset", int'(bus.in_ready_o), 1);
    send(50, 5, 1'b1, 1'b0);
    drain();
    rnd = 1'b1;
    for (int i = 0; i < 1000; i++) begin
      a = int'($urandom_range(0, 4095)) - 2048;
      do b = int'($urandom_range(0, 255)) - 128; while (b == 0);
      send(a, b, 1'b1, $urandom_range(0, 1) == 1);
    end
    drain();
    rnd = 1'b0;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
